// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file (regfile_mp).
// Optional write-first bypass is selected by the REGFILE_BYPASS_EN macro in the read ports.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-entry, busy and (with REGFILE_BYPASS_EN) write-first muxing.
// Without REGFILE_BYPASS_EN the port is read-first: it returns the pre-write array content.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] mem_q,
   output logic [DATA_W-1:0] rdata
);

   logic byp;

`ifdef REGFILE_BYPASS_EN
   assign byp = wr_en && (waddr == raddr);
`else
   logic unused_byp;
   assign unused_byp = &{1'b0, wr_en, waddr, wdata};
   assign byp        = 1'b0;
`endif

   // Zero-entry rule sits above the bypass so entry 0 never returns write data.
   always_ff @(posedge clk) begin
      if (rst || busy)
         rdata <= '0;
      else if (ZERO_REG && (raddr == '0))
         rdata <= '0;
      else if (byp)
         rdata <= wdata;
      else
         rdata <= mem_q;
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD registered read ports, one write port, sequential clear after reset.
// Build option: define REGFILE_BYPASS_EN for write-first reads on a same-cycle address match.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic                     busy
);

   localparam int              DEPTH    = depth_of(ADDR_W);
   localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_en;
   logic              wr_keep;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         CLEAR: begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST)
               state_nxt = READY;
         end
         READY: ;
         default: state_nxt = CLEAR;
      endcase
   end

   assign busy    = (state == CLEAR);
   assign wr_en   = (state == READY) && we;
   assign wr_keep = wr_en && !(ZERO_REG && (waddr == '0));

   // NOTE: the array has no reset branch; the CLEAR walk zeroes it one entry per cycle instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            mem[clr_cnt[ADDR_W-1:0]] <= '0;
         else if (wr_keep)
            mem[waddr] <= wdata;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = raddr[p*ADDR_W +: ADDR_W];

      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .clk   (clk),
         .rst   (rst),
         .busy  (busy),
         .wr_en (wr_en),
         .waddr (waddr),
         .wdata (wdata),
         .raddr (ra),
         .mem_q (mem[ra]),
         .rdata (rdata[p*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: behavioural model with per-cycle compare on a default 2-port instance,
// plus directed checks on a small 4-port, ZERO_REG=0 instance. Honors REGFILE_BYPASS_EN.
module tb_regfile_mp;

   localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [9:0]  raddr = '0;
   logic [63:0] rdata;
   logic        busy;

   logic        s_rst = 1'b0;
   logic        s_we = 1'b0;
   logic [2:0]  s_waddr = '0;
   logic [15:0] s_wdata = '0;
   logic [11:0] s_raddr = '0;
   logic [63:0] s_rdata;
   logic        s_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .busy(busy)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b0)) dut_small (
      .clk(clk), .rst(s_rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
      .raddr(s_raddr), .rdata(s_rdata), .busy(s_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: busy lasts DEPTH cycles after the last reset, after which every entry is zero.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] exp_rd [2];
   int          m_left = 0;
   bit          m_init = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_left = DEPTH;
         m_init = 1'b1;
         foreach (m_mem[i]) m_mem[i] = '0;
         foreach (exp_rd[p]) exp_rd[p] = '0;
      end else if (m_init) begin
         if (m_left > 0) begin
            m_left--;
            foreach (exp_rd[p]) exp_rd[p] = '0;
         end else begin
            for (int p = 0; p < 2; p++) begin
               logic [4:0] a;
               a = raddr[p*5 +: 5];
               if (a == 0)                     exp_rd[p] = '0;
               else if (BYP && we && waddr == a) exp_rd[p] = wdata;
               else                            exp_rd[p] = m_mem[a];
            end
            if (we && waddr != 0) m_mem[waddr] = wdata;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("busy_model", 64'(busy), 64'(m_left > 0));
         for (int p = 0; p < 2; p++)
            check($sformatf("rdata%0d_model", p), 64'(rdata[p*32 +: 32]), 64'(exp_rd[p]));
      end
   end

   task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1);
      rst = r; we = w; waddr = wa; wdata = wd; raddr = {r1, r0};
      @(posedge clk);
      #1;
   endtask

   task automatic sstep(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [11:0] ra);
      s_rst = r; s_we = w; s_waddr = wa; s_wdata = wd; s_raddr = ra;
      @(posedge clk);
      #1;
   endtask

   // Counts busy cycles starting at the reset edge, writing r3 throughout; bounded at 100.
   task automatic count_busy(output int n);
      n = 1;
      while (busy === 1'b1 && n < 100) begin
         step(0, 1, 5'd3, 32'hA5A5A5A5, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         if (busy === 1'b1) n++;
      end
   endtask

   initial begin
      int n;

      // Test 1: reset, clear length, all entries zero.
      step(1, 0, 0, 0, 0, 0);
      check("reset_busy", 64'(busy), 64'd1);
      check("reset_rdata", rdata, 64'd0);
      count_busy(n);
      check("clear_len", 64'(n), 64'd32);
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0, 0, 0, 5'(a), 5'(31 - a));
         check("cleared_p0", 64'(rdata[31:0]), 64'd0);
         check("cleared_p1", 64'(rdata[63:32]), 64'd0);
      end

      // Test 2: write then read.
      step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
      step(0, 0, 0, 0, 5'd5, 5'd5);
      check("r5_p0", 64'(rdata[31:0]), 64'hDEADBEEF);
      check("r5_p1", 64'(rdata[63:32]), 64'hDEADBEEF);

      // Test 3: same-cycle write and read.
      step(0, 1, 5'd7, 32'h00000001, 0, 0);
      step(0, 1, 5'd7, 32'h12345678, 5'd7, 5'd5);
      check("r7_same", 64'(rdata[31:0]), BYP ? 64'h12345678 : 64'h00000001);
      check("r5_other_port", 64'(rdata[63:32]), 64'hDEADBEEF);
      step(0, 0, 0, 0, 5'd7, 0);
      check("r7_next", 64'(rdata[31:0]), 64'h12345678);

      // Test 4: hardwired zero entry, including same-cycle write.
      step(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
      check("r0_same", rdata, 64'd0);
      step(0, 0, 0, 0, 0, 0);
      check("r0_after", rdata, 64'd0);

      // Test 5: reset restart mid-clear; r3 written before, and throughout the clear.
      step(0, 1, 5'd3, 32'h00000055, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 5'd3, 32'hA5A5A5A5, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      count_busy(n);
      check("restart_len", 64'(n), 64'd32);
      step(0, 0, 0, 0, 5'd3, 5'd3);
      check("r3_cleared", rdata, 64'd0);

      // Random phase against the model; narrow address range forces collisions.
      for (int i = 0; i < 1500; i++) begin
         logic [4:0] wa, r0, r1;
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         r0 = 5'($urandom_range(0, 7));
         r1 = ($urandom_range(0, 1) == 0) ? r0 : 5'($urandom_range(0, 7));
         step($urandom_range(0, 399) == 0, 1'($urandom), wa, $urandom, r0, r1);
      end
      step(0, 0, 0, 0, 0, 0);

      // Test 6 and ZERO_REG=0: small 4-port instance.
      sstep(1, 0, 0, 0, 0);
      check("s_reset_busy", 64'(s_busy), 64'd1);
      n = 1;
      while (s_busy === 1'b1 && n < 100) begin
         sstep(0, 0, 0, 0, 0);
         if (s_busy === 1'b1) n++;
      end
      check("s_clear_len", 64'(n), 64'd8);
      sstep(0, 1, 3'd0, 16'hFFFF, 0);
      sstep(0, 0, 0, 0, 0);
      check("s_r0", 64'(s_rdata[15:0]), 64'hFFFF);
      for (int i = 1; i <= 4; i++) sstep(0, 1, 3'(i), 16'(16'h1111 * i), 0);
      sstep(0, 0, 0, 0, {3'd4, 3'd3, 3'd2, 3'd1});
      for (int p = 0; p < 4; p++)
         check($sformatf("s_port%0d", p), 64'(s_rdata[p*16 +: 16]), 64'(16'h1111 * (p + 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
